dmux8_rr_scheduler: RTL
=======================

// Module: dmux8_rr_scheduler
// PURPOSE
//  Round-robin scheduler sharing one 16-bit write path among 8 requesters.
//  Each cycle it picks one requester and drives the 8-way 16-bit demux
//  (sel/d) plus a one-hot load vector into the downstream 8-register bank.
//  Output is registered, with 1-cycle latency and a sink-side stall for backpressure.
//  Sits between the producers (PC/ALU/IO writers) and the register/RAM8 bank.
// PARAMETERS
//  DATA_W     16  width of each requester's data word and of out_d
//  N_PORTS    8   number of requesters/destinations; fixed at 8 (SEL_W=3)
//  RESET_PTR  7   last-grant pointer value after reset (7 => port 0 wins first)
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          synchronous, active-high reset
//  req        in   8          req[i]=1: requester i has a word pending
//  wdata      in   8*DATA_W   packed words; port i = wdata[i*16 +: 16]
//  stall      in   1          sink cannot accept the current transfer
//  ack        out  8          one-hot pulse: requester i's word was taken
//  out_sel    out  3          demux select = granted port index
//  out_d      out  DATA_W     demux data input
//  out_load   out  8          one-hot load strobe to destination registers
//  out_valid  out  1          out_sel/out_d/out_load carry a transfer
//  tx_count   out  16         count of completed transfers, wraps at 2^16
// BEHAVIOUR
//  - Reset (reset=1 at an edge): ptr<=RESET_PTR; out_valid<=0, out_sel<=0,
//    out_d<=0, out_load<=0, ack<=0, tx_count<=0. Reset wins over all other
//    events. A transfer in flight is dropped and not counted.
//  - Slot free: free = !out_valid | !stall. A transfer completes on a cycle
//    with out_valid & !stall. tx_count increments on that edge.
//  - FSM, 2 states. IDLE (out_valid=0) and BUSY (out_valid=1).
//    IDLE: if |req, issue -> BUSY; otherwise stay.
//    BUSY & stall: hold. All outputs stay frozen, ack=0, req is ignored.
//    BUSY & !stall & |req: issue the next word back-to-back, staying BUSY.
//    BUSY & !stall & !req: -> IDLE. out_valid, out_load and out_d go to 0.
//  - Issue on the edge: w = first i with req[i]=1, scanning ptr+1, ptr+2, ...
//    mod 8. Then out_sel<=w, out_d<=wdata[w], out_load<=1<<w,
//    out_valid<=1, ack<=1<<w for exactly 1 cycle, ptr<=w.
//  - ack is asserted during the cycle the word first appears on out_*.
//    The requester treats data as consumed and must present its next word
//    (or drop req) in that same cycle.
//  - Latency: req sampled at edge k -> out_valid at k+1. Throughput is 1 word
//    per cycle when stall=0.
//  - Fairness: with all 8 req held high, grant order is 0,1,...,7,0. Any
//    requester waits at most 7 grants.
//  - stall while IDLE has no effect; issue proceeds normally.
//  - Invariants: out_load is one-hot or zero, and nonzero iff out_valid;
//    out_load == (1<<out_sel) when out_valid=1; ack has at most 1 bit set.
// STRUCTURE
//  - Package dmux8_pkg holds N_PORTS=8, SEL_W=3, DATA_W=16,
//    typedef sel_t=logic[2:0], and typedef word_t=logic[15:0].
//  - Sub-module rr_pick8 is pure combinational: (req[7:0], ptr[2:0]) ->
//    (found, idx[2:0]), computed by rotate, priority-encode, un-rotate.
//  - The top level holds the state register, ptr, output registers and tx_count.
// TESTING
//  1. Reset, then req=8'h01, wdata[0]=16'hBEEF -> next cycle: out_sel=0,
//     out_d=BEEF, out_load=8'h01, ack=8'h01; tx_count=1 after the following edge.
//  2. req=8'hFF held for 9 cycles, stall=0 -> out_sel sequence 0..7,0 and
//     tx_count=9.
//  3. Issue port 5 (16'h1234), then stall=1 for 3 cycles with req=8'h08 ->
//     out_* frozen at sel=5/1234/8'h20, ack=0; stall drop -> next out_sel=3.
//  4. ptr=6, req=8'h81 -> grant 7 then 0, since the scan wraps past index 7.
//  5. reset=1 mid-BUSY with stall=1 -> next cycle every output is 0, and
//     tx_count stays 0.
//  6. Force tx_count=16'hFFFF, then complete 1 transfer -> tx_count=0.

Source files
------------

// File: rtl/dmux8_pkg.sv
// Shared widths, types and FSM encoding for the 8-port round-robin write scheduler.
package dmux8_pkg;
  localparam int N_PORTS = 8;
  localparam int SEL_W   = 3;
  localparam int DATA_W  = 16;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first requester after ptr, found by
// rotating req so ptr+1 lands at bit 0, priority-encoding, then un-rotating.
module rr_pick8
  import dmux8_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);
  sel_t               base;
  sel_t               offset;
  logic [N_PORTS-1:0] rot;

  assign base = ptr + sel_t'(1);

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_rot
      sel_t src;
      assign src     = base + sel_t'(gi);
      assign rot[gi] = req[src];
    end
  endgenerate

  // Scan from the top down so the lowest set rotated bit wins.
  always_comb begin
    offset = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (rot[k]) offset = sel_t'(k);
    end
  end

  assign found = |req;
  assign idx   = base + offset;
endmodule

// File: rtl/dmux8_rr_scheduler.sv
// Round-robin scheduler sharing one registered write path among 8 requesters,
// driving demux select/data and a one-hot load strobe with sink backpressure.
module dmux8_rr_scheduler #(
  parameter int         DATA_W    = 16,
  parameter int         N_PORTS   = 8,
  parameter logic [2:0] RESET_PTR = 3'd7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_PORTS-1:0]        req,
  input  logic [N_PORTS*DATA_W-1:0] wdata,
  input  logic                      stall,
  output logic [N_PORTS-1:0]        ack,
  output logic [2:0]                out_sel,
  output logic [DATA_W-1:0]         out_d,
  output logic [N_PORTS-1:0]        out_load,
  output logic                      out_valid,
  output logic [15:0]               tx_count
);
  import dmux8_pkg::*;

  state_t              state_reg, state_next;
  sel_t                ptr_reg;
  sel_t                sel_reg;
  logic [DATA_W-1:0]   d_reg;
  logic [N_PORTS-1:0]  load_reg;
  logic [N_PORTS-1:0]  ack_reg;
  logic [15:0]         count_reg;

  logic                pick_found;
  sel_t                pick_idx;
  logic [DATA_W-1:0]   pick_word;
  logic [N_PORTS-1:0]  pick_onehot;
  logic                issue;
  logic                complete;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign pick_word   = wdata[pick_idx*DATA_W +: DATA_W];
  assign pick_onehot = {{(N_PORTS-1){1'b0}}, 1'b1} << pick_idx;
  assign complete    = (state_reg == ST_BUSY) && !stall;

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          issue      = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!stall) begin
          if (pick_found) begin
            issue = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= RESET_PTR;
      sel_reg   <= '0;
      d_reg     <= '0;
      load_reg  <= '0;
      ack_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= issue ? pick_onehot : '0;
      if (issue) begin
        sel_reg  <= pick_idx;
        d_reg    <= pick_word;
        load_reg <= pick_onehot;
        ptr_reg  <= pick_idx;
      end else if (complete) begin
        // Draining to idle: select is left as-is, data and strobe clear.
        d_reg    <= '0;
        load_reg <= '0;
      end
      if (complete) count_reg <= count_reg + 16'd1;
    end
  end

  assign out_valid = (state_reg == ST_BUSY);
  assign out_sel   = sel_reg;
  assign out_d     = d_reg;
  assign out_load  = load_reg;
  assign ack       = ack_reg;
  assign tx_count  = count_reg;
endmodule
